pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 33 +++
 rtl/pipeline_hazard_ctrl_if.sv | 37 +++
 rtl/pipeline_hazard_ctrl_load_use_detect.sv | 15 +
 rtl/pipeline_hazard_ctrl.sv | 118 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline control types: FSM encoding, NOP/bubble encoding and the
// bundle of stage-control strobes produced by the hazard controller.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MDU_WAIT = 1'b1
  } hz_state_e;

  // RV32I canonical NOP (addi x0, x0, 0) loaded into a stage as a bubble.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_bubble;
    logic mdu_start;
    logic mdu_abort;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_DEFAULT = '{
    pc_write:     1'b1,
    ifid_write:   1'b1,
    ifid_flush:   1'b0,
    idex_flush:   1'b0,
    exmem_bubble: 1'b0,
    mdu_start:    1'b0,
    mdu_abort:    1'b0
  };

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bus: pipeline stage status in, stall/flush/MDU strobes out.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       ifId_Rs1;
  logic [4:0]       ifId_Rs2;
  logic             ifId_UseRs2;
  logic [4:0]       idEx_Rd;
  logic             idEx_MemRead;
  logic             idEx_MduOp;
  logic             branchTaken;
  logic             mduDone;
  logic             pcWrite;
  logic             ifIdWrite;
  logic             ifIdFlush;
  logic             idExFlush;
  logic             exMemBubble;
  logic             mduStart;
  logic             mduAbort;
  logic             mduErr;
  logic [CNT_W-1:0] stallCnt;

  modport master (
    output ifId_Rs1, ifId_Rs2, ifId_UseRs2, idEx_Rd, idEx_MemRead,
           idEx_MduOp, branchTaken, mduDone,
    input  pcWrite, ifIdWrite, ifIdFlush, idExFlush, exMemBubble,
           mduStart, mduAbort, mduErr, stallCnt
  );

  modport slave (
    input  ifId_Rs1, ifId_Rs2, ifId_UseRs2, idEx_Rd, idEx_MemRead,
           idEx_MduOp, branchTaken, mduDone,
    output pcWrite, ifIdWrite, ifIdFlush, idExFlush, exMemBubble,
           mduStart, mduAbort, mduErr, stallCnt
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use comparator: EX holds a load whose destination feeds the ID instruction.
module load_use_detect (
  input  logic       mem_read_i,
  input  logic [4:0] rd_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic       use_rs2_i,
  output logic       hazard_o
);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign hazard_o = mem_read_i && (rd_i != 5'd0) &&
                    ((rd_i == rs1_i) || (use_rs2_i && (rd_i == rs2_i)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and multi-cycle
// MDU freeze with watchdog abort and a saturating stall counter.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int WDOG_MAX = 63
) (
  input logic                  clk,
  input logic                  rst_n,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int WDOG_W = (WDOG_MAX < 2) ? 1 : $clog2(WDOG_MAX + 1);

  hz_state_e        state_q, state_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             mdu_err_q, mdu_err_d;
  hz_ctrl_t         ctrl_s;
  logic             load_use_s;

  load_use_detect u_load_use_detect (
    .mem_read_i (bus.idEx_MemRead),
    .rd_i       (bus.idEx_Rd),
    .rs1_i      (bus.ifId_Rs1),
    .rs2_i      (bus.ifId_Rs2),
    .use_rs2_i  (bus.ifId_UseRs2),
    .hazard_o   (load_use_s)
  );

  // Control strobes and next-state; outputs fall back to defaults while in reset.
  always_comb begin
    ctrl_s    = CTRL_DEFAULT;
    state_d   = state_q;
    wdog_d    = wdog_q;
    mdu_err_d = mdu_err_q;
    if (!rst_n) begin
      ctrl_s = CTRL_DEFAULT;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.branchTaken) begin
            ctrl_s.ifid_flush = 1'b1;
            ctrl_s.idex_flush = 1'b1;
          end else if (bus.idEx_MduOp) begin
            ctrl_s.mdu_start    = 1'b1;
            ctrl_s.pc_write     = 1'b0;
            ctrl_s.ifid_write   = 1'b0;
            ctrl_s.exmem_bubble = 1'b1;
            state_d             = ST_MDU_WAIT;
            wdog_d              = '0;
          end else if (load_use_s) begin
            ctrl_s.pc_write   = 1'b0;
            ctrl_s.ifid_write = 1'b0;
            ctrl_s.idex_flush = 1'b1;
          end else begin
            ctrl_s = CTRL_DEFAULT;
          end
        end
        ST_MDU_WAIT: begin
          // A result arriving on the watchdog limit cycle still completes normally.
          if (bus.mduDone) begin
            state_d = ST_RUN;
          end else if (wdog_q == WDOG_W'(WDOG_MAX)) begin
            ctrl_s.mdu_abort = 1'b1;
            mdu_err_d        = 1'b1;
            state_d          = ST_RUN;
          end else begin
            ctrl_s.pc_write     = 1'b0;
            ctrl_s.ifid_write   = 1'b0;
            ctrl_s.exmem_bubble = 1'b1;
            wdog_d              = wdog_q + WDOG_W'(1);
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // Saturating stall counter next value.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!ctrl_s.pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State, watchdog, stall counter and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      wdog_q      <= '0;
      stall_cnt_q <= '0;
      mdu_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wdog_q      <= wdog_d;
      stall_cnt_q <= stall_cnt_d;
      mdu_err_q   <= mdu_err_d;
    end
  end

  assign bus.pcWrite     = ctrl_s.pc_write;
  assign bus.ifIdWrite   = ctrl_s.ifid_write;
  assign bus.ifIdFlush   = ctrl_s.ifid_flush;
  assign bus.idExFlush   = ctrl_s.idex_flush;
  assign bus.exMemBubble = ctrl_s.exmem_bubble;
  assign bus.mduStart    = ctrl_s.mdu_start;
  assign bus.mduAbort    = ctrl_s.mdu_abort;
  assign bus.mduErr      = mdu_err_q;
  assign bus.stallCnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; control strobes compared as
// {pcWrite, ifIdWrite, ifIdFlush, idExFlush, exMemBubble, mduStart, mduAbort}.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 8;
  localparam logic [6:0] C_DEF   = 7'b1100000;
  localparam logic [6:0] C_LU    = 7'b0001000;
  localparam logic [6:0] C_BR    = 7'b1111000;
  localparam logic [6:0] C_START = 7'b0000110;
  localparam logic [6:0] C_WAIT  = 7'b0000100;
  localparam logic [6:0] C_ABORT = 7'b1100001;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .WDOG_MAX(63)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [6:0] ctl();
    return {bus.pcWrite, bus.ifIdWrite, bus.ifIdFlush, bus.idExFlush,
            bus.exMemBubble, bus.mduStart, bus.mduAbort};
  endfunction

  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic use2, input logic br,
                       input logic mdu, input logic done);
    bus.idEx_MemRead = mr;
    bus.idEx_Rd      = rd;
    bus.ifId_Rs1     = rs1;
    bus.ifId_Rs2     = rs2;
    bus.ifId_UseRs2  = use2;
    bus.branchTaken  = br;
    bus.idEx_MduOp   = mdu;
    bus.mduDone      = done;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Check the strobes for the cycle currently driven, then advance one edge.
  task automatic cyc(input string tag, input logic [6:0] exp);
    #1;
    check_val(tag, {25'd0, ctl()}, {25'd0, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #3;
    check_val("reset_ctl", {25'd0, ctl()}, {25'd0, C_DEF});
    check_val("reset_cnt", {24'd0, bus.stallCnt}, 32'd0);
    check_val("reset_err", {31'd0, bus.mduErr}, 32'd0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    cyc("idle", C_DEF);
    check_val("idle_cnt", {24'd0, bus.stallCnt}, 32'd0);

    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("lu_rs1", C_LU);
    idle();
    cyc("lu_rs1_after", C_DEF);
    check_val("lu_rs1_cnt", {24'd0, bus.stallCnt}, 32'd1);

    drive(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("lu_rs2", C_LU);
    drive(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("lu_rs2_unused", C_DEF);
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("lu_x0", C_DEF);
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("branch_lu", C_BR);
    check_val("branch_cnt", {24'd0, bus.stallCnt}, 32'd2);

    // MDU completes after five frozen wait cycles; branch/load-use ignored meanwhile.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("mdu_start", C_START);
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc("mdu_wait", C_WAIT);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc("mdu_done", C_DEF);
    idle();
    cyc("mdu_run", C_DEF);
    check_val("mdu_cnt", {24'd0, bus.stallCnt}, 32'd8);
    check_val("mdu_err0", {31'd0, bus.mduErr}, 32'd0);

    // Done on the watchdog limit cycle wins over the abort.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("wdb_start", C_START);
    for (int i = 0; i < 63; i++) cyc("wdb_wait", C_WAIT);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc("wdb_done", C_DEF);
    idle();
    cyc("wdb_run", C_DEF);
    check_val("wdb_err", {31'd0, bus.mduErr}, 32'd0);
    check_val("wdb_cnt", {24'd0, bus.stallCnt}, 32'd72);

    // No done: abort after 63 frozen wait cycles.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("wd_start", C_START);
    for (int i = 0; i < 63; i++) cyc("wd_wait", C_WAIT);
    cyc("wd_abort", C_ABORT);
    check_val("wd_err", {31'd0, bus.mduErr}, 32'd1);
    check_val("wd_cnt", {24'd0, bus.stallCnt}, 32'd136);
    drive(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("wd_run_lu", C_LU);
    check_val("wd_err_sticky", {31'd0, bus.mduErr}, 32'd1);
    check_val("wd_run_cnt", {24'd0, bus.stallCnt}, 32'd137);

    // Saturation of the stall counter.
    for (int i = 0; i < 125; i++) cyc("sat_lu", C_LU);
    check_val("sat_cnt", {24'd0, bus.stallCnt}, 32'd255);
    for (int i = 0; i < 5; i++) cyc("sat_hold", C_LU);
    check_val("sat_nowrap", {24'd0, bus.stallCnt}, 32'd255);

    // Reset in the middle of an MDU wait.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("rst_mdu_start", C_START);
    cyc("rst_mdu_wait", C_WAIT);
    cyc("rst_mdu_wait", C_WAIT);
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_ctl", {25'd0, ctl()}, {25'd0, C_DEF});
    check_val("rst_mid_cnt", {24'd0, bus.stallCnt}, 32'd0);
    check_val("rst_mid_err", {31'd0, bus.mduErr}, 32'd0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc("rst_run", C_DEF);
    check_val("rst_run_cnt", {24'd0, bus.stallCnt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
